dm_arbiter: RTL and testbench
=============================

# dm_arbiter

Shares one single-ported data memory between the single-cycle MIPS core's load/store port and an external host port (debug/DMA loader). Sits between the core's data-memory signals and the memory macro. It drives `cpu_stall` to freeze the core while the memory is busy, and it bounds host starvation with a wait counter. Supports memories with a fixed read latency of 1–4 cycles.

## Interface
- `RD_LAT`, 2: memory read latency in cycles, from `mem_en` to valid `mem_rd`. Legal range is 1..4.
- `MAX_WAIT`, 3: consecutive losing cycles after which the host overrides CPU priority. Legal range is 1..15.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `cpu_req`  in  1  core executing lw/sw; held until `cpu_stall` is low.
- `cpu_we`  in  1  1 = sw, 0 = lw.
- `cpu_addr`  in  32  core address (`alu_out`).
- `cpu_wd`  in  32  core store data.
- `cpu_rd`  out  32  load data; valid in the cycle the CPU read completes.
- `cpu_stall`  out  1  freeze PC and register-file write.
- `host_req`  in  1  host request; level, held with addr/we/wd until `host_ack`.
- `host_we`  in  1  1 = write.
- `host_addr`  in  32  host address.
- `host_wd`  in  32  host write data.
- `host_rd`  out  32  host read data; valid in the `host_ack` cycle.
- `host_ack`  out  1  one-cycle completion pulse.
- `mem_en`  out  1  one-cycle access strobe.
- `mem_we`  out  1  write enable, qualified by `mem_en`.
- `mem_addr`  out  32  memory address.
- `mem_wd`  out  32  memory write data.
- `mem_rd`  in  32  memory read data, valid `RD_LAT` cycles after `mem_en`.

## Operation
- **State.** FSM states are IDLE and RD_WAIT. Additional registers:
  - `owner` (CPU/HOST)
  - latched address
  - `cnt` (2 bits)
  - `host_wait` (4 bits, saturating at `MAX_WAIT`)
- **IDLE, winner selection.** Issues happen only in IDLE. If exactly one requester asserts its request, it wins. If both request, the CPU wins unless `host_wait >= MAX_WAIT`, in which case the host wins.
- **IDLE, issue cycle.** Outputs are combinational from the winner:
  - `mem_en=1`
  - `mem_we`/`mem_addr`/`mem_wd` taken from the winner's inputs
- **Write issue.** The write completes in the issue cycle and the FSM stays in IDLE. A CPU write sees `cpu_stall=0`; a host write sees `host_ack=1`.
- **Read issue.** Latch the address and `owner`, load `cnt=RD_LAT-1`, go to RD_WAIT.
- **RD_WAIT.** Each cycle:
  - `mem_en=0`, `mem_we=0`
  - `mem_addr` holds the latched address
  - `cnt` decrements
  - no new issue
- **Done cycle (RD_WAIT with `cnt==0`).** If the CPU owns the read, `cpu_stall=0`. If the host owns it, `host_ack=1`. Next state is IDLE.
- **Back-to-back timing.** Reads from any requester issue at most once every `RD_LAT+1` cycles. Writes can issue every cycle.
- **`cpu_stall` definition.** Asserted when `cpu_req=1`, except in these two cycles:
  - a cycle where the CPU's write issues;
  - the done cycle of the CPU's own read.
  This includes IDLE cycles where the host wins and every RD_WAIT cycle.
- **Read data paths.** `cpu_rd` and `host_rd` are wired from `mem_rd`; they are meaningful only in the respective done cycle.
- **`host_wait` counter.**
  - Increments each cycle that `host_req=1` and the host is not issued.
  - Clears when the host issues or when `host_req=0`.
  - Saturates at `MAX_WAIT`.
- **Host handshake.** `host_req` still high in the cycle after `host_ack` is a new request.
- **CPU request hold.** The CPU holds its request through its own done cycle, but no re-issue occurs because RD_WAIT blocks issue. The next IDLE cycle belongs to the next instruction.

## Timing
- **Reset (`rst=0`, asynchronous).** State=IDLE, `cnt=0`, `host_wait=0`, `owner`=CPU. While `rst` is low, outputs are forced:
  - `mem_en=0`, `mem_we=0`
  - `host_ack=0`, `cpu_stall=0`
  - `mem_addr=0`, `mem_wd=0`
- **Reset during RD_WAIT.** The transaction is abandoned and no ack or stall release is produced for it. The requester reissues after reset.
- **Read latency.** Issued at cycle t, the read completes at t+`RD_LAT`. A CPU read stalls for `RD_LAT` cycles.
- **Write latency.** Zero added cycles when uncontended.
- **Worst-case host wait.** `MAX_WAIT` losing cycles plus the remainder of any in-flight read.

## Test plan
All scenarios use `RD_LAT=2`, `MAX_WAIT=3`.
- **CPU store, host idle.** Release reset; CPU sw addr 0x10, wd 0xDEADBEEF. Same cycle: `mem_en=1`, `mem_we=1`, `mem_addr=0x10`, `mem_wd=0xDEADBEEF`, `cpu_stall=0`.
- **CPU load.** CPU lw 0x20 at t; memory returns 0x12345678 at t+2.
  - `mem_en=1` only at t.
  - `cpu_stall=1` at t and t+1.
  - At t+2: `cpu_stall=0`, `cpu_rd=0x12345678`.
  - `mem_addr=0x20` throughout.
- **Host read, CPU idle.** Host read 0x40 at t; memory returns 0xA5A5A5A5.
  - `host_ack=1` only at t+2, with `host_rd=0xA5A5A5A5`.
  - `host_req` held high at t+3 reissues.
- **Host starvation.** CPU sw every cycle from cycle 0; host read held from cycle 0.
  - CPU writes issue in cycles 0–2.
  - Host issues in cycle 3.
  - `cpu_stall=1` in cycles 3–5.
  - `host_ack` in cycle 5.
  - CPU write issues in cycle 6.
- **Simultaneous requests.** CPU lw and host write both arrive at t with `host_wait=0`.
  - CPU read issues at t and completes at t+2.
  - Host write issues at t+3 with `host_ack=1` at t+3.
- **Reset mid-read.** Host read issued at t; `rst` low at t+1 for 2 cycles.
  - `mem_en=0` and `host_ack=0` throughout.
  - After release, FSM is in IDLE; the held `host_req` reissues and acks 2 cycles later.

Source files
------------

// File: rtl/dm_arbiter.sv
// Arbitrates one single-ported data memory between the core's load/store port
// and a host port; CPU has priority until the host has waited MAX_WAIT cycles.
module dm_arbiter #(
  parameter int RD_LAT   = 2,
  parameter int MAX_WAIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wd,
  output logic [31:0] cpu_rd,
  output logic        cpu_stall,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [31:0] host_addr,
  input  logic [31:0] host_wd,
  output logic [31:0] host_rd,
  output logic        host_ack,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);
  typedef enum logic {IDLE, RD_WAIT} state_t;
  typedef enum logic {OWN_CPU, OWN_HOST} owner_t;

  localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);
  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  state_t      state_q, state_d;
  owner_t      owner_q, owner_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [3:0]  host_wait_q, host_wait_d;

  logic        cpu_win, host_win;
  logic        iss_en, iss_we, stall_rel, ack;
  logic [31:0] iss_addr, iss_wd;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    cpu_win     = 1'b0;
    host_win    = 1'b0;
    iss_en      = 1'b0;
    iss_we      = 1'b0;
    iss_addr    = addr_q;
    iss_wd      = '0;
    stall_rel   = 1'b0;
    ack         = 1'b0;
    case (state_q)
      IDLE: begin
        host_win = host_req && (!cpu_req || host_wait_q >= WAIT_MAX);
        cpu_win  = cpu_req && !host_win;
        if (cpu_win || host_win) begin
          iss_en   = 1'b1;
          iss_we   = host_win ? host_we   : cpu_we;
          iss_addr = host_win ? host_addr : cpu_addr;
          iss_wd   = host_win ? host_wd   : cpu_wd;
          if (!iss_we) begin
            state_d = RD_WAIT;
            owner_d = host_win ? OWN_HOST : OWN_CPU;
            addr_d  = iss_addr;
            cnt_d   = CNT_INIT;
          end else if (cpu_win) begin
            stall_rel = 1'b1;
          end else begin
            ack = 1'b1;
          end
        end
      end
      RD_WAIT: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd0) begin
          state_d = IDLE;
          cnt_d   = 2'd0;
          if (owner_q == OWN_HOST) ack = 1'b1;
          else                     stall_rel = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Any cycle the host asks but is not issued counts toward overriding the CPU.
    if (host_req && !host_win)
      host_wait_d = (host_wait_q >= WAIT_MAX) ? WAIT_MAX : host_wait_q + 4'd1;
    else
      host_wait_d = 4'd0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_CPU;
      addr_q      <= '0;
      cnt_q       <= '0;
      host_wait_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      host_wait_q <= host_wait_d;
    end
  end

  // Outputs are quiet while reset is held, even if requests are pending.
  assign cpu_stall = rst && cpu_req && !stall_rel;
  assign host_ack  = rst && ack;
  assign mem_en    = rst && iss_en;
  assign mem_we    = rst && iss_en && iss_we;
  assign mem_addr  = rst ? iss_addr : 32'd0;
  assign mem_wd    = rst ? iss_wd : 32'd0;
  assign cpu_rd    = mem_rd;
  assign host_rd   = mem_rd;
endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed test-plan scenarios with literal checks, then
// randomized traffic compared every cycle against a timestamp-based model.
module tb_dm_arbiter;
  localparam int RD_LAT   = 2;
  localparam int MAX_WAIT = 3;

  logic        clk = 1'b0, rst = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wd = '0;
  logic        host_req = 1'b0, host_we = 1'b0;
  logic [31:0] host_addr = '0, host_wd = '0;
  logic [31:0] cpu_rd, host_rd, mem_addr, mem_wd, mem_rd;
  logic        cpu_stall, host_ack, mem_en, mem_we;

  always #5 clk = ~clk;

  dm_arbiter #(.RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
    .cpu_rd(cpu_rd), .cpu_stall(cpu_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wd(host_wd),
    .host_rd(host_rd), .host_ack(host_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .mem_rd(mem_rd)
  );

  int nvec = 0, nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Initial memory contents; two locations carry the test-plan values.
  function automatic logic [31:0] dflt(input logic [31:0] a);
    if (a == 32'h20) return 32'h1234_5678;
    if (a == 32'h40) return 32'hA5A5_A5A5;
    return a ^ 32'h5A5A_0000;
  endfunction

  // Memory macro with a fixed read latency.
  logic [31:0] mem_arr [64];
  bit   [63:0] mem_wr;
  logic [31:0] rdp [4];
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      mem_arr[mem_addr[7:2]] <= mem_wd;
      mem_wr[mem_addr[7:2]]  <= 1'b1;
    end
    rdp[0] <= (mem_en && !mem_we) ?
              (mem_wr[mem_addr[7:2]] ? mem_arr[mem_addr[7:2]] : dflt(mem_addr)) : 32'h0BAD_0BAD;
    for (int i = 1; i < 4; i++) rdp[i] <= rdp[i-1];
  end
  assign mem_rd = rdp[RD_LAT-1];

  // Reference model: reads are tracked by their completion timestamp.
  logic [31:0] ref_mem [64];
  bit   [63:0] ref_wr;
  bit          pend, own_h, m_cpu_done, m_host_ack;
  int          done_at, hw, cyc;
  logic [31:0] lat_addr, lat_data;

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_wr[a[7:2]] ? ref_mem[a[7:2]] : dflt(a);
  endfunction

  always @(negedge clk) begin : model
    bit e_en, e_we, e_ack, e_stall, cwr, crd, win_c, win_h, chk_a;
    logic [31:0] e_addr, e_wd;
    m_cpu_done = 1'b0;
    m_host_ack = 1'b0;
    if (!rst) begin
      pend = 1'b0;
      hw   = 0;
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_host_ack", host_ack, 0);
      chk("rst_cpu_stall", cpu_stall, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wd", mem_wd, 0);
    end else begin
      e_en = 0; e_we = 0; e_ack = 0; cwr = 0; crd = 0; win_c = 0; win_h = 0; chk_a = 0;
      e_addr = '0; e_wd = '0;
      if (pend) begin
        chk_a  = 1;
        e_addr = lat_addr;
        if (cyc == done_at) begin
          pend = 1'b0;
          if (own_h) begin e_ack = 1; chk("host_rd", host_rd, lat_data); end
          else       begin crd = 1;   chk("cpu_rd", cpu_rd, lat_data); end
        end
      end else begin
        win_c = cpu_req && !(host_req && hw >= MAX_WAIT);
        win_h = host_req && !win_c;
        if (win_c || win_h) begin
          e_en   = 1;
          chk_a  = 1;
          e_we   = win_h ? host_we : cpu_we;
          e_addr = win_h ? host_addr : cpu_addr;
          e_wd   = win_h ? host_wd : cpu_wd;
          if (e_we) begin
            ref_mem[e_addr[7:2]] = e_wd;
            ref_wr[e_addr[7:2]]  = 1'b1;
            if (win_c) cwr = 1; else e_ack = 1;
          end else begin
            pend     = 1'b1;
            own_h    = win_h;
            done_at  = cyc + RD_LAT;
            lat_addr = e_addr;
            lat_data = ref_rd(e_addr);
          end
        end
      end
      e_stall = cpu_req && !cwr && !crd;
      hw = (host_req && !win_h) ? ((hw < MAX_WAIT) ? hw + 1 : MAX_WAIT) : 0;
      chk("mem_en", mem_en, e_en);
      chk("mem_we", mem_we, e_we);
      chk("host_ack", host_ack, e_ack);
      chk("cpu_stall", cpu_stall, e_stall);
      if (chk_a) chk("mem_addr", mem_addr, e_addr);
      if (e_en && e_we) chk("mem_wd", mem_wd, e_wd);
      m_cpu_done = cpu_req && !e_stall;
      m_host_ack = e_ack;
    end
    cyc++;
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic mid();  @(negedge clk); #2; endtask

  initial begin
    int rst_hold;
    rst_hold = 0;
    // Reset forces outputs low even with both requesters active.
    cpu_req = 1; host_req = 1;
    mid();
    chk("lit_rst_en", mem_en, 0); chk("lit_rst_stall", cpu_stall, 0); chk("lit_rst_ack", host_ack, 0);

    // CPU store, host idle.
    tick(); rst = 1; host_req = 0; cpu_we = 1; cpu_addr = 32'h10; cpu_wd = 32'hDEAD_BEEF;
    mid();
    chk("lit_sw_en", mem_en, 1); chk("lit_sw_we", mem_we, 1); chk("lit_sw_addr", mem_addr, 32'h10);
    chk("lit_sw_wd", mem_wd, 32'hDEAD_BEEF); chk("lit_sw_stall", cpu_stall, 0);

    // CPU load.
    tick(); cpu_we = 0; cpu_addr = 32'h20;
    mid(); chk("lit_lw_en0", mem_en, 1); chk("lit_lw_stall0", cpu_stall, 1); chk("lit_lw_addr0", mem_addr, 32'h20);
    tick(); mid(); chk("lit_lw_en1", mem_en, 0); chk("lit_lw_stall1", cpu_stall, 1); chk("lit_lw_addr1", mem_addr, 32'h20);
    tick(); mid(); chk("lit_lw_stall2", cpu_stall, 0); chk("lit_lw_rd", cpu_rd, 32'h1234_5678);
    chk("lit_lw_addr2", mem_addr, 32'h20);

    // Host read, CPU idle; held request reissues after the ack.
    tick(); cpu_req = 0; host_req = 1; host_we = 0; host_addr = 32'h40;
    mid(); chk("lit_hr_en", mem_en, 1); chk("lit_hr_ack0", host_ack, 0);
    tick(); mid(); chk("lit_hr_ack1", host_ack, 0);
    tick(); mid(); chk("lit_hr_ack2", host_ack, 1); chk("lit_hr_rd", host_rd, 32'hA5A5_A5A5);
    tick(); mid(); chk("lit_hr_reissue", mem_en, 1); chk("lit_hr_readdr", mem_addr, 32'h40);
    tick(); tick(); mid(); chk("lit_hr_reack", host_ack, 1);
    tick(); host_req = 0;

    // Host starvation bound.
    for (int i = 0; i < 7; i++) begin
      tick();
      cpu_req = 1; cpu_we = 1; host_req = (i < 6); host_we = 0; host_addr = 32'h40;
      if (i <= 3 || i == 6) begin cpu_addr = 32'h80 + 32'(4 * i); cpu_wd = 32'(i); end
      mid();
      if (i < 3 || i == 6) begin
        chk("lit_st_cpu_en", mem_en, 1); chk("lit_st_cpu_we", mem_we, 1); chk("lit_st_stall", cpu_stall, 0);
      end else begin
        chk("lit_st_stall_h", cpu_stall, 1);
        chk("lit_st_ack", host_ack, (i == 5) ? 1 : 0);
        if (i == 3) begin chk("lit_st_h_en", mem_en, 1); chk("lit_st_h_addr", mem_addr, 32'h40); end
      end
    end

    // Simultaneous CPU load and host write.
    tick(); cpu_req = 1; cpu_we = 0; cpu_addr = 32'h20;
    host_req = 1; host_we = 1; host_addr = 32'h50; host_wd = 32'h11;
    mid(); chk("lit_sim_en", mem_en, 1); chk("lit_sim_addr", mem_addr, 32'h20); chk("lit_sim_ack0", host_ack, 0);
    tick(); mid(); chk("lit_sim_stall1", cpu_stall, 1);
    tick(); mid(); chk("lit_sim_stall2", cpu_stall, 0); chk("lit_sim_rd", cpu_rd, 32'h1234_5678);
    tick(); cpu_req = 0;
    mid(); chk("lit_sim_hw_we", mem_we, 1); chk("lit_sim_hw_addr", mem_addr, 32'h50); chk("lit_sim_hw_ack", host_ack, 1);

    // Reset in the middle of a host read.
    tick(); host_we = 0; host_addr = 32'h40;
    mid(); chk("lit_rr_en", mem_en, 1);
    tick(); rst = 0; mid(); chk("lit_rr_en1", mem_en, 0); chk("lit_rr_ack1", host_ack, 0);
    tick(); mid(); chk("lit_rr_en2", mem_en, 0); chk("lit_rr_ack2", host_ack, 0);
    tick(); rst = 1; mid(); chk("lit_rr_reissue", mem_en, 1); chk("lit_rr_ack3", host_ack, 0);
    tick(); mid(); chk("lit_rr_ack4", host_ack, 0);
    tick(); mid(); chk("lit_rr_ack5", host_ack, 1);
    tick(); host_req = 0;

    // Randomized traffic; requests are held until the model says they completed.
    for (int k = 0; k < 3000; k++) begin
      tick();
      if (!cpu_req || m_cpu_done) begin
        cpu_req  = ($urandom_range(0, 3) != 0);
        cpu_we   = $urandom_range(0, 1);
        cpu_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        cpu_wd   = $urandom;
      end
      if (!host_req || m_host_ack) begin
        host_req  = ($urandom_range(0, 2) == 0);
        host_we   = $urandom_range(0, 1);
        host_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        host_wd   = $urandom;
      end
      if (!rst) begin
        if (rst_hold > 0) rst_hold--;
        else rst = 1;
      end else if ($urandom_range(0, 199) == 0) begin
        rst = 0;
        rst_hold = $urandom_range(0, 1);
      end
    end
    tick(); rst = 1; cpu_req = 0; host_req = 0;
    tick(); tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
